wb_pipe_master: RTL and testbench

WB_PIPE_MASTER -- requirements
Module: wb_pipe_master

---
 rtl/wb_pipe_master.sv | 119 +++++++++++
 tb/tb_wb_pipe_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_master.sv
// Wishbone B4 pipelined bus master.
// Turns a valid/ready request stream into pipelined Wishbone transfers,
// keeps up to MaxOutstanding transfers in flight, and returns one response
// per termination in issue order.
module wb_pipe_master #(
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 30,
  parameter int MaxOutstanding = 4,
  localparam int SelWidth      = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  // Request side
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_data_i,
  input  logic [SelWidth-1:0]  req_sel_i,
  input  logic                 req_we_i,
  // Response side (no backpressure)
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_err_o,
  // Wishbone slave-side inputs
  input  logic [DataWidth-1:0] wb_data_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_stall_i,
  input  logic                 wb_err_i,
  // Wishbone master outputs
  output logic [DataWidth-1:0] wb_data_o,
  output logic [AddrWidth-1:0] wb_addr_o,
  output logic [SelWidth-1:0]  wb_sel_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o
);

  localparam int CountWidth = $clog2(MaxOutstanding + 1);
  // One extra bit so "count + pending stb" cannot overflow before the compare.
  localparam logic [CountWidth:0] MaxCount = (CountWidth + 1)'(MaxOutstanding);

  logic [CountWidth-1:0] count;       // transfers taken by the slave, not yet terminated
  logic [CountWidth-1:0] count_next;
  logic [CountWidth:0]   inflight;    // count plus the transfer currently on stb
  logic                  issue;       // slave takes the transfer on stb this cycle
  logic                  term;        // a termination that matches an outstanding transfer
  logic                  accept;
  logic                  stb_next;

  // Handshake, issue/termination events and next counter value.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    count_next  = count;
    issue       = wb_stb_o && !wb_stall_i;
    // Terminations with nothing outstanding are spurious and ignored.
    term        = (wb_ack_i || wb_err_i) && (count != '0);
    inflight    = {1'b0, count} + {{CountWidth{1'b0}}, wb_stb_o};
    // A new request may load only if the stb slot frees this cycle and the
    // resulting in-flight total stays within the limit.
    req_ready_o = (!wb_stb_o || !wb_stall_i) && (inflight < MaxCount);
    accept      = req_valid_i && req_ready_o;
    // New acceptance keeps stb high (back-to-back); otherwise stb holds while stalled.
    stb_next    = accept || (wb_stb_o && wb_stall_i);
    if (issue && !term) begin
      count_next = count + CountWidth'(1);
    end else if (term && !issue) begin
      count_next = count - CountWidth'(1);
    end
  end

  // Request channel: payload loads on acceptance and holds otherwise (stable under stall).
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_sel_o  <= '0;
    end else begin
      wb_stb_o <= stb_next;
      if (accept) begin
        wb_we_o   <= req_we_i;
        wb_addr_o <= req_addr_i;
        wb_data_o <= req_data_i;
        wb_sel_o  <= req_sel_i;
      end
    end
  end

  // Outstanding counter and the registered cycle envelope derived from next state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count    <= '0;
      wb_cyc_o <= 1'b0;
    end else begin
      count    <= count_next;
      wb_cyc_o <= stb_next || (count_next != '0);
    end
  end

  // Response: one-cycle pulse after each valid termination; err wins over ack.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= term;
      rsp_err_o   <= term && wb_err_i;
      if (term) begin
        rsp_data_o <= wb_data_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_master.sv
// Self-checking bench for wb_pipe_master: a transaction-level reference model
// (queue of accepted-but-unissued requests, count of issued-but-unterminated
// transfers, expected response) is compared every cycle, plus a table of
// single-transfer vectors and directed multi-cycle sequences.
module tb_wb_pipe_master;

  localparam int DW   = 32;
  localparam int AW   = 30;
  localparam int SW   = DW / 8;
  localparam int MAXO = 4;

  logic          clk_i;
  logic          reset_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_data_i;
  logic [SW-1:0] req_sel_i;
  logic          req_we_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic [DW-1:0] wb_data_i;
  logic          wb_ack_i;
  logic          wb_stall_i;
  logic          wb_err_i;
  logic [DW-1:0] wb_data_o;
  logic [AW-1:0] wb_addr_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;

  wb_pipe_master #(
    .DataWidth(DW),
    .AddrWidth(AW),
    .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_sel_i(req_sel_i),
    .req_we_i(req_we_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o),
    .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i),
    .wb_err_i(wb_err_i),
    .wb_data_o(wb_data_o),
    .wb_addr_o(wb_addr_o),
    .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic          we;
  } req_t;

  req_t          pend_q[$];     // accepted, waiting for the slave to take it
  int            outst;         // taken by the slave, not yet terminated
  logic          exp_rv;
  logic [DW-1:0] exp_rd;
  logic          exp_re;
  int            rsp_seen;      // observed response pulses
  int            issued_seen;   // observed transfers taken by the slave
  logic          rsp_err_log[$];

  task automatic reset_model();
    pend_q.delete();
    outst  = 0;
    exp_rv = 1'b0;
    exp_rd = '0;
    exp_re = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic step();
    logic rdy_exp, acc, iss, trm;
    req_t cur;
    @(negedge clk_i);
    rdy_exp = (pend_q.size() == 0 || !wb_stall_i) && (outst + pend_q.size() < MAXO);
    check("req_ready", 64'(req_ready_o), 64'(rdy_exp));
    check("wb_stb", 64'(wb_stb_o), 64'(pend_q.size() != 0));
    check("wb_cyc", 64'(wb_cyc_o), 64'(pend_q.size() != 0 || outst != 0));
    if (pend_q.size() != 0) begin
      cur = pend_q[0];
      check("wb_addr", 64'(wb_addr_o), 64'(cur.addr));
      check("wb_data", 64'(wb_data_o), 64'(cur.data));
      check("wb_sel", 64'(wb_sel_o), 64'(cur.sel));
      check("wb_we", 64'(wb_we_o), 64'(cur.we));
    end
    check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
    if (exp_rv) begin
      check("rsp_data", 64'(rsp_data_o), 64'(exp_rd));
      check("rsp_err", 64'(rsp_err_o), 64'(exp_re));
    end
    if (rsp_valid_o) begin
      rsp_seen++;
      rsp_err_log.push_back(rsp_err_o);
    end
    if (wb_stb_o && !wb_stall_i) issued_seen++;
    acc = req_valid_i && rdy_exp;
    iss = (pend_q.size() != 0) && !wb_stall_i;
    trm = (wb_ack_i || wb_err_i) && (outst > 0);
    exp_rv = trm;
    exp_rd = wb_data_i;
    exp_re = wb_err_i;
    if (iss) begin
      void'(pend_q.pop_front());
      outst++;
    end
    if (trm) outst--;
    if (acc) pend_q.push_back('{req_addr_i, req_data_i, req_sel_i, req_we_i});
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cyc"}, 64'(wb_cyc_o), 64'(0));
    check({tag, "_stb"}, 64'(wb_stb_o), 64'(0));
    check({tag, "_we"}, 64'(wb_we_o), 64'(0));
    check({tag, "_addr"}, 64'(wb_addr_o), 64'(0));
    check({tag, "_wdata"}, 64'(wb_data_o), 64'(0));
    check({tag, "_sel"}, 64'(wb_sel_o), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
    check({tag, "_rsp_data"}, 64'(rsp_data_o), 64'(0));
    check({tag, "_rsp_err"}, 64'(rsp_err_o), 64'(0));
    check({tag, "_ready"}, 64'(req_ready_o), 64'(1));
  endtask

  // Issue n reads back-to-back as fast as the master allows, then let the last one go out.
  task automatic send_reads(input int n, input logic [AW-1:0] base);
    int   sent = 0;
    logic fire;
    for (int c = 0; c < 4 * n + 8 && sent < n; c++) begin
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_sel_i   = '1;
      req_addr_i  = base + AW'(sent);
      #1 fire = req_ready_o;
      step();
      if (fire) sent++;
    end
    req_valid_i = 1'b0;
    check("send_accepted", 64'(sent), 64'(n));
    repeat (2) step();
  endtask

  // ---------------- single-transfer vector table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    int            delay;     // cycles from stb to termination (>= 1)
    logic          ack;
    logic          err;
    logic [DW-1:0] sdata;     // slave data driven with the termination
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   sent;
    logic fire;

    vecs[0] = '{1'b0, 30'h10,       32'h0,        4'hF, 2, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 30'h20,       32'h12345678, 4'hF, 1, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[2] = '{1'b0, 30'h3FFFFFFF, 32'h0,        4'hF, 3, 1'b0, 1'b1, 32'h0BADC0DE, 32'h0BADC0DE, 1'b1};
    vecs[3] = '{1'b1, 30'h0,        32'hFFFFFFFF, 4'h3, 1, 1'b1, 1'b1, 32'h55AA55AA, 32'h55AA55AA, 1'b1};
    vecs[4] = '{1'b0, 30'h155,      32'h0,        4'h1, 4, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0};

    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_sel_i   = '0;
    req_we_i    = 1'b0;
    wb_data_i   = '0;
    wb_ack_i    = 1'b0;
    wb_stall_i  = 1'b0;
    wb_err_i    = 1'b0;
    reset_i     = 1'b0;
    rsp_seen    = 0;
    issued_seen = 0;
    reset_model();

    // Reset state
    #1 reset_i = 1'b1;
    #2 check_idle("reset");
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Table of single transfers
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1;
      req_we_i    = vecs[i].we;
      req_addr_i  = vecs[i].addr;
      req_data_i  = vecs[i].wdata;
      req_sel_i   = vecs[i].sel;
      step();
      req_valid_i = 1'b0;
      check("vec_stb", 64'(wb_stb_o), 64'(1));
      check("vec_addr", 64'(wb_addr_o), 64'(vecs[i].addr));
      check("vec_we", 64'(wb_we_o), 64'(vecs[i].we));
      check("vec_sel", 64'(wb_sel_o), 64'(vecs[i].sel));
      step();
      check("vec_stb_one_cycle", 64'(wb_stb_o), 64'(0));
      for (int d = 1; d < vecs[i].delay; d++) step();
      wb_ack_i  = vecs[i].ack;
      wb_err_i  = vecs[i].err;
      wb_data_i = vecs[i].sdata;
      step();
      wb_ack_i  = 1'b0;
      wb_err_i  = 1'b0;
      wb_data_i = '0;
      check("vec_rsp_valid", 64'(rsp_valid_o), 64'(1));
      check("vec_rsp_data", 64'(rsp_data_o), 64'(vecs[i].exp_data));
      check("vec_rsp_err", 64'(rsp_err_o), 64'(vecs[i].exp_err));
      check("vec_cyc_fall", 64'(wb_cyc_o), 64'(0));
      step();
      check("vec_rsp_pulse", 64'(rsp_valid_o), 64'(0));
    end

    // Stall: write held for 3 cycles, taken on the 4th
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 30'h20;
    req_data_i  = 32'h12345678;
    req_sel_i   = 4'hF;
    step();
    req_valid_i = 1'b0;
    wb_stall_i  = 1'b1;
    issued_seen = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 64'(req_ready_o), 64'(0));
      check("stall_stb", 64'(wb_stb_o), 64'(1));
      check("stall_addr", 64'(wb_addr_o), 64'(30'h20));
      check("stall_data", 64'(wb_data_o), 64'(32'h12345678));
      check("stall_sel", 64'(wb_sel_o), 64'(4'hF));
      check("stall_we", 64'(wb_we_o), 64'(1));
      step();
    end
    wb_stall_i = 1'b0;
    #1 check("stall_release_ready", 64'(req_ready_o), 64'(1));
    step();
    check("stall_taken_once", 64'(issued_seen), 64'(1));
    check("stall_stb_fall", 64'(wb_stb_o), 64'(0));
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    step();

    // Outstanding limit: 6 reads with acks withheld
    sent        = 0;
    issued_seen = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid_i = (sent < 6);
      req_we_i    = 1'b0;
      req_addr_i  = AW'(32'h100 + sent);
      #1 fire = req_valid_i && req_ready_o;
      step();
      if (fire) sent++;
    end
    req_valid_i = 1'b0;
    check("limit_stb_transfers", 64'(issued_seen), 64'(MAXO));
    check("limit_accepted", 64'(sent), 64'(MAXO));
    #1 check("limit_ready_full", 64'(req_ready_o), 64'(0));
    rsp_seen = 0;
    for (int c = 0; c < 40 && rsp_seen < 6; c++) begin
      req_valid_i = (sent < 6);
      req_addr_i  = AW'(32'h100 + sent);
      wb_ack_i    = 1'b1;
      wb_data_i   = 32'hA0000000 + DW'(c);
      #1 fire = req_valid_i && req_ready_o;
      step();
      if (fire) sent++;
    end
    req_valid_i = 1'b0;
    wb_ack_i    = 1'b0;
    repeat (2) step();
    check("limit_responses", 64'(rsp_seen), 64'(6));
    check("limit_cyc_idle", 64'(wb_cyc_o), 64'(0));

    // Error on the second of three transfers, then a spurious ack
    send_reads(3, 30'h200);
    rsp_err_log.delete();
    wb_data_i = 32'h11111111;
    wb_ack_i  = 1'b1;
    step();
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b1;
    step();
    wb_err_i  = 1'b0;
    wb_ack_i  = 1'b1;
    step();
    wb_ack_i  = 1'b0;
    step();
    check("err_rsp_count", 64'(rsp_err_log.size()), 64'(3));
    if (rsp_err_log.size() == 3) begin
      for (int j = 0; j < 3; j++) check("err_rsp_flag", 64'(rsp_err_log[j]), 64'(j == 1));
    end
    rsp_seen = 0;
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    repeat (2) step();
    check("spurious_no_rsp", 64'(rsp_seen), 64'(0));

    // Issue and ack in the same cycle at count 2
    send_reads(2, 30'h300);
    req_valid_i = 1'b1;
    req_addr_i  = 30'h302;
    step();
    req_valid_i = 1'b0;
    rsp_seen    = 0;
    wb_ack_i    = 1'b1;
    wb_data_i   = 32'h22222222;
    step();
    wb_ack_i    = 1'b0;
    #1 check("simul_ready_count2", 64'(req_ready_o), 64'(1));
    step();
    wb_ack_i = 1'b1;
    repeat (6) step();
    wb_ack_i = 1'b0;
    repeat (2) step();
    check("simul_responses", 64'(rsp_seen), 64'(3));

    // Reset with three transfers outstanding
    send_reads(3, 30'h400);
    check("pre_reset_cyc", 64'(wb_cyc_o), 64'(1));
    #2 reset_i = 1'b1;
    #1 check_idle("midreset");
    reset_model();
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    rsp_seen = 0;
    wb_ack_i = 1'b1;
    repeat (4) step();
    wb_ack_i = 1'b0;
    step();
    check("post_reset_no_rsp", 64'(rsp_seen), 64'(0));

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req_valid_i = ($urandom_range(0, 9) < 6);
      req_we_i    = 1'($urandom_range(0, 1));
      req_addr_i  = AW'($urandom);
      req_data_i  = DW'($urandom);
      req_sel_i   = SW'($urandom);
      wb_stall_i  = ($urandom_range(0, 9) < 3);
      wb_ack_i    = ($urandom_range(0, 9) < 4);
      wb_err_i    = ($urandom_range(0, 9) < 1);
      wb_data_i   = DW'($urandom);
      step();
    end
    req_valid_i = 1'b0;
    wb_stall_i  = 1'b0;
    wb_err_i    = 1'b0;
    wb_ack_i    = 1'b1;
    repeat (12) step();
    wb_ack_i = 1'b0;
    repeat (2) step();
    check("final_cyc_idle", 64'(wb_cyc_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
